// File: rtl/wb_pkg.sv
// Shared widths and source encoding for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_SRC = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MDU = 1'b1
  } src_e;

  // Index of the granted source; only meaningful when exactly one grant bit is set.
  function automatic src_e gnt_to_src(input logic [NUM_SRC-1:0] gnt);
    return gnt[1] ? SRC_MDU : SRC_ALU;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with the rotation pointer held internally.
module rr_arb2
  import wb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] gnt
);

  src_e ptr_q, ptr_d;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || ptr_q == SRC_ALU)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  // After a grant, priority moves to the source that lost.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != '0)) begin
      ptr_d = gnt[0] ? SRC_MDU : SRC_ALU;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and MUL/DIV/load results onto the single
// register-file write port, one write per cycle, never writing x0.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [REG_AW-1:0] s0_addr,
  input  logic [DWIDTH-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [REG_AW-1:0] s1_addr,
  input  logic [DWIDTH-1:0] s1_data,
  output logic              regw,
  output logic [REG_AW-1:0] waddr,
  output logic [DWIDTH-1:0] wdata,
  output logic              last_src
);

  logic [NUM_SRC-1:0] req_c;
  logic [NUM_SRC-1:0] gnt_c;
  logic               xfer_c;
  src_e               src_c;
  logic [REG_AW-1:0]  sel_addr_c;
  logic [DWIDTH-1:0]  sel_data_c;

  logic              regw_q,     regw_d;
  logic [REG_AW-1:0] waddr_q,    waddr_d;
  logic [DWIDTH-1:0] wdata_q,    wdata_d;
  src_e              last_src_q, last_src_d;

  // Hold and reset both mask requests so no grant (and no pointer move) can occur.
  assign req_c = {s1_valid, s0_valid} & {NUM_SRC{~(hold | reset)}};

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_c),
    .advance (xfer_c),
    .gnt     (gnt_c)
  );

  assign s0_ready   = gnt_c[0];
  assign s1_ready   = gnt_c[1];
  assign xfer_c     = |gnt_c;
  assign src_c      = gnt_to_src(gnt_c);
  assign sel_addr_c = (src_c == SRC_MDU) ? s1_addr : s0_addr;
  assign sel_data_c = (src_c == SRC_MDU) ? s1_data : s0_data;

  // x0 writes still consume the grant and update the payload, but never assert regw.
  always_comb begin
    regw_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    last_src_d = last_src_q;
    if (xfer_c) begin
      regw_d     = (sel_addr_c != '0);
      waddr_d    = sel_addr_c;
      wdata_d    = sel_data_c;
      last_src_d = src_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regw_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      last_src_q <= SRC_ALU;
    end else begin
      regw_q     <= regw_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      last_src_q <= last_src_d;
    end
  end

  assign regw     = regw_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign last_src = last_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: per-cycle ready checks plus next-cycle
// writeback checks, with hand sequences for reset corner cases.
module tb_wb_arbiter;

  localparam int unsigned DW = 32;

  logic          clock;
  logic          reset;
  logic          hold;
  logic          s0_valid, s1_valid;
  logic          s0_ready, s1_ready;
  logic [4:0]    s0_addr, s1_addr;
  logic [DW-1:0] s0_data, s1_data;
  logic          regw;
  logic [4:0]    waddr;
  logic [DW-1:0] wdata;
  logic          last_src;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.DWIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .regw     (regw),
    .waddr    (waddr),
    .wdata    (wdata),
    .last_src (last_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          hold;
    logic          v0;
    logic [4:0]    a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [4:0]    a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic          regw;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic          last;
  } vec_t;

  vec_t vecs[$];

  // Pending-request record for the source stability obligation.
  logic          pend0, pend1;
  logic [4:0]    pa0, pa1;
  logic [DW-1:0] pd0, pd1;

  function automatic vec_t mk(logic h, logic v0, logic [4:0] a0, logic [DW-1:0] d0,
                              logic v1, logic [4:0] a1, logic [DW-1:0] d1,
                              logic r0, logic r1, logic rw, logic [4:0] wa,
                              logic [DW-1:0] wd, logic ls);
    vec_t v;
    v.hold = h;  v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1;   v.a1 = a1; v.d1 = d1;
    v.r0 = r0;   v.r1 = r1; v.regw = rw; v.waddr = wa; v.wdata = wd; v.last = ls;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs (called just after a negedge), then check readies.
  task automatic apply(input vec_t v, input int idx);
    hold = v.hold;
    s0_valid = v.v0; s0_addr = v.a0; s0_data = v.d0;
    s1_valid = v.v1; s1_addr = v.a1; s1_data = v.d1;
    #1;
    if (pend0) chk($sformatf("v%0d s0 stable", idx), 64'({s0_valid, s0_addr, s0_data}), 64'({1'b1, pa0, pd0}));
    if (pend1) chk($sformatf("v%0d s1 stable", idx), 64'({s1_valid, s1_addr, s1_data}), 64'({1'b1, pa1, pd1}));
    chk($sformatf("v%0d s0_ready", idx), 64'(s0_ready), 64'(v.r0));
    chk($sformatf("v%0d s1_ready", idx), 64'(s1_ready), 64'(v.r1));
    chk($sformatf("v%0d one-hot ready", idx), 64'(s0_ready & s1_ready), 64'(0));
    pend0 = s0_valid && !s0_ready && !reset; pa0 = s0_addr; pd0 = s0_data;
    pend1 = s1_valid && !s1_ready && !reset; pa1 = s1_addr; pd1 = s1_data;
  endtask

  task automatic chk_out(input string tag, input logic rw, input logic [4:0] wa,
                         input logic [DW-1:0] wd, input logic ls);
    chk({tag, " regw"},     64'(regw),     64'(rw));
    chk({tag, " waddr"},    64'(waddr),    64'(wa));
    chk({tag, " wdata"},    64'(wdata),    64'(wd));
    chk({tag, " last_src"}, 64'(last_src), 64'(ls));
  endtask

  initial begin
    pend0 = 1'b0; pend1 = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;

    // Reset vectors walk rr, hold and x0 cases; each row's outputs are seen the next cycle.
    vecs.push_back(mk(0, 1,5,32'hDEADBEEF, 0,0,0,            1,0, 1,5,32'hDEADBEEF,1'b0));
    vecs.push_back(mk(0, 0,0,0,            1,3,32'h33,       0,1, 1,3,32'h33,1'b1));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 1,1,32'h11, 1,2,32'h22,           1,0, 1,1,32'h11,1'b0));
      vecs.push_back(mk(0, 1,1,32'h11, 1,2,32'h22,           0,1, 1,2,32'h22,1'b1));
    end
    vecs.push_back(mk(0, 1,1,32'h11, 0,0,0,                  1,0, 1,1,32'h11,1'b0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,                  0,0, 0,1,32'h11,1'b0));
    vecs.push_back(mk(0, 0,0,0,      1,0,32'h1234,           0,1, 0,0,32'h1234,1'b1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 1,1,32'h11, 1,2,32'h22,           0,0, 0,0,32'h1234,1'b1));
    vecs.push_back(mk(0, 1,1,32'h11, 1,2,32'h22,             1,0, 1,1,32'h11,1'b0));
    vecs.push_back(mk(0, 0,0,0,      1,2,32'h22,             0,1, 1,2,32'h22,1'b1));
    vecs.push_back(mk(1, 1,4,32'h44, 0,0,0,                  0,0, 0,2,32'h22,1'b1));
    vecs.push_back(mk(0, 1,4,32'h44, 0,0,0,                  1,0, 1,4,32'h44,1'b0));
    vecs.push_back(mk(0, 1,7,32'hA,  1,7,32'hB,              0,1, 1,7,32'hB,1'b1));
    vecs.push_back(mk(0, 1,7,32'hA,  0,0,0,                  1,0, 1,7,32'hA,1'b0));
    vecs.push_back(mk(0, 1,0,32'h55, 1,6,32'h66,             0,1, 1,6,32'h66,1'b1));
    vecs.push_back(mk(0, 1,0,32'h55, 0,0,0,                  1,0, 0,0,32'h55,1'b0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,                  0,0, 0,0,32'h55,1'b0));

    // Reset held with both sources requesting: nothing granted, outputs cleared.
    reset = 1'b1; hold = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h1;
    s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 32'h2;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("reset s0_ready", 64'(s0_ready), 64'(0));
    chk("reset s1_ready", 64'(s1_ready), 64'(0));
    chk_out("reset", 1'b0, 5'd0, 32'd0, 1'b0);

    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) begin
      apply(vecs[i], i);
      @(posedge clock); #1;
      chk_out($sformatf("v%0d", i), vecs[i].regw, vecs[i].waddr, vecs[i].wdata, vecs[i].last);
      @(negedge clock);
    end

    // Transfer then reset mid-flight: regw drops at once, transfer during reset is lost.
    apply(mk(0, 1,9,32'h99, 0,0,0, 1,0, 0,0,0,0), 100);
    @(posedge clock); #1;
    chk_out("pre-reset", 1'b1, 5'd9, 32'h99, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'h77;
    #1;
    chk_out("mid-reset", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("mid-reset s0_ready", 64'(s0_ready), 64'(0));
    chk("mid-reset s1_ready", 64'(s1_ready), 64'(0));
    pend0 = 1'b0; pend1 = 1'b0;
    @(posedge clock); #1;
    chk_out("reset-cycle", 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_out("post-release", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("post-release s0_ready", 64'(s0_ready), 64'(1));
    chk("post-release s1_ready", 64'(s1_ready), 64'(0));
    @(posedge clock); #1;
    chk_out("post-release wb", 1'b1, 5'd9, 32'h99, 1'b0);
    @(negedge clock); #1;
    chk("post-release rr s1_ready", 64'(s1_ready), 64'(1));
    @(posedge clock); #1;
    chk_out("post-release wb2", 1'b1, 5'd3, 32'h77, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
